// File: rtl/md_issue_ctrl_pkg.sv
// Shared HI/LO multiply/divide opcode encodings, default latencies and issue-FSM state codes.
// Imported by the issue controller, the HI/LO unit and the D-stage decoder.
package md_issue_ctrl_pkg;

   localparam logic [4:0] MD_NONE  = 5'd0;
   localparam logic [4:0] MD_MULTU = 5'd1;
   localparam logic [4:0] MD_MULT  = 5'd2;
   localparam logic [4:0] MD_DIVU  = 5'd3;
   localparam logic [4:0] MD_DIV   = 5'd4;
   localparam logic [4:0] MD_MFHI  = 5'd5;
   localparam logic [4:0] MD_MFLO  = 5'd6;
   localparam logic [4:0] MD_MTHI  = 5'd7;
   localparam logic [4:0] MD_MTLO  = 5'd8;

   localparam int MD_MULT_CYC = 5;
   localparam int MD_DIV_CYC  = 10;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Encodings above MD_MTLO are reserved and behave as MD_NONE.
   function automatic logic md_op_known(input logic [4:0] op);
      return op <= MD_MTLO;
   endfunction

   function automatic logic md_op_is_mul(input logic [4:0] op);
      return (op == MD_MULTU) || (op == MD_MULT);
   endfunction

   function automatic logic md_op_is_div(input logic [4:0] op);
      return (op == MD_DIVU) || (op == MD_DIV);
   endfunction

   function automatic logic md_op_is_mt(input logic [4:0] op);
      return (op == MD_MTHI) || (op == MD_MTLO);
   endfunction

endpackage

// File: rtl/md_issue_ctrl.sv
// E-stage issue and interlock controller for the HI/LO multiply/divide unit.
// Shadows the unit's fixed latency to drive the D-stage stall and a sticky sync-error flag.
module md_issue_ctrl
   import md_issue_ctrl_pkg::*;
#(
   parameter int MULT_CYC = MD_MULT_CYC,
   parameter int DIV_CYC  = MD_DIV_CYC,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       e_valid,
   input  logic [4:0] e_md_op,
   input  logic       e_flush,
   input  logic       d_md_use,
   input  logic       md_busy,
   output logic       md_start,
   output logic [4:0] md_ctrl,
   output logic       md_wr_en,
   output logic       md_rd_hi,
   output logic       stall_d,
   output logic       md_sync_err
);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] lat_q, lat_d;
   logic             err_q, err_d;

   logic kill;
   logic in_run;
   logic op_mul;
   logic op_long;
   logic issue;

   always_comb begin
      kill    = e_flush | ~e_valid;
      in_run  = (state_q == ST_RUN);
      op_mul  = md_op_is_mul(e_md_op);
      op_long = op_mul | md_op_is_div(e_md_op);
      issue   = ~in_run & ~kill & op_long;
   end

   // While RUN the unit samples wr_en on its commit edge, so it is held high for the whole run.
   always_comb begin
      md_start    = issue;
      md_ctrl     = (in_run | kill | ~md_op_known(e_md_op)) ? '0 : e_md_op;
      md_wr_en    = in_run | (~kill & md_op_is_mt(e_md_op));
      md_rd_hi    = (e_md_op == MD_MFHI);
      stall_d     = d_md_use & (in_run | issue);
      md_sync_err = err_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      err_d   = err_q;
      if (in_run) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
         // First RUN cycle is excused (busy may still be settling); the commit cycle is too.
         if (~md_busy && (cnt_q != lat_q) && (cnt_q != CNT_W'(1))) err_d = 1'b1;
      end else if (issue) begin
         state_d = ST_RUN;
         cnt_d   = op_mul ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);
         lat_d   = cnt_d;
      end else if (md_busy) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         lat_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl: stimulus pushes expected outputs from a
// cycle-count reference model; a negedge monitor pops and compares.
module tb_md_issue_ctrl;

   localparam int LAT_MUL = 5;
   localparam int LAT_DIV = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       e_valid;
   logic [4:0] e_md_op;
   logic       e_flush;
   logic       d_md_use;
   logic       md_busy;
   logic       md_start;
   logic [4:0] md_ctrl;
   logic       md_wr_en;
   logic       md_rd_hi;
   logic       stall_d;
   logic       md_sync_err;

   md_issue_ctrl #(.MULT_CYC(LAT_MUL), .DIV_CYC(LAT_DIV), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_op(e_md_op),
      .e_flush(e_flush), .d_md_use(d_md_use), .md_busy(md_busy),
      .md_start(md_start), .md_ctrl(md_ctrl), .md_wr_en(md_wr_en),
      .md_rd_hi(md_rd_hi), .stall_d(stall_d), .md_sync_err(md_sync_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       start;
      logic [4:0] ctrl;
      logic       wr;
      logic       rd_hi;
      logic       stall;
      logic       err;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: remaining in-flight cycles of the unit, its total latency, sticky error.
   int   rem = 0;
   int   lat = 0;
   logic err_m = 1'b0;
   int   busy_mode = 0;  // 0 follows unit model, 1 forces busy high, 2 forces busy low

   task automatic chk(input string name, input int act, input int expv);
      n_checks++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("md_start", int'(md_start), int'(e.start));
         chk("md_ctrl", int'(md_ctrl), int'(e.ctrl));
         chk("md_wr_en", int'(md_wr_en), int'(e.wr));
         chk("md_rd_hi", int'(md_rd_hi), int'(e.rd_hi));
         chk("stall_d", int'(stall_d), int'(e.stall));
         chk("md_sync_err", int'(md_sync_err), int'(e.err));
      end
   end

   // One clock cycle: drive inputs, predict outputs, then advance the model across the edge.
   task automatic cyc(input logic v, input int op, input logic fl, input logic du, input logic rst);
      exp_t e;
      int   opn;
      logic kill, idle, long_op, iss;
      reset    = rst;
      e_valid  = v;
      e_md_op  = 5'(op);
      e_flush  = fl;
      d_md_use = du;
      md_busy  = (busy_mode == 1) ? 1'b1 : (busy_mode == 2) ? 1'b0 : (rem > 0);

      kill    = fl || !v;
      opn     = (op <= 8) ? op : 0;
      idle    = (rem == 0);
      long_op = (opn >= 1) && (opn <= 4);
      iss     = idle && !kill && long_op;

      e.start = iss;
      e.ctrl  = (idle && !kill) ? 5'(opn) : 5'd0;
      e.wr    = idle ? (!kill && (opn == 7 || opn == 8)) : 1'b1;
      e.rd_hi = (op == 5);
      e.stall = du && (!idle || iss);
      e.err   = err_m;
      sb.push_back(e);

      @(posedge clk);
      if (rst) begin
         rem   = 0;
         err_m = 1'b0;
      end else begin
         if (!idle && !md_busy && (rem != lat) && (rem > 1)) err_m = 1'b1;
         if (idle && !iss && md_busy) err_m = 1'b1;
         if (iss) begin
            lat = (opn <= 2) ? LAT_MUL : LAT_DIV;
            rem = lat;
         end else if (rem > 0) begin
            rem--;
         end
      end
      #1;
   endtask

   task automatic wait_cycles(input int n, input logic du);
      for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, du, 1'b0);
   endtask

   initial begin
      reset = 1'b1; e_valid = 1'b0; e_md_op = '0; e_flush = 1'b0; d_md_use = 1'b0; md_busy = 1'b0;
      @(posedge clk); #1;
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);

      // mult with dependent D instruction: stall cycles 0..5, free in cycle 6
      cyc(1'b1, 2, 1'b0, 1'b1, 1'b0);
      wait_cycles(5, 1'b1);
      cyc(1'b1, 5, 1'b0, 1'b1, 1'b0);

      // div then mflo: 11 stalled cycles, then mflo in E reads LO
      cyc(1'b1, 4, 1'b0, 1'b1, 1'b0);
      wait_cycles(10, 1'b1);
      cyc(1'b1, 6, 1'b0, 1'b0, 1'b0);

      // mthi killed by flush, then mthi that writes
      cyc(1'b1, 7, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 7, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 8, 1'b0, 1'b0, 1'b0);

      // multu, flush in RUN cycle 2 does not abort
      cyc(1'b1, 1, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 0, 1'b1, 1'b1, 1'b0);
      wait_cycles(3, 1'b1);
      cyc(1'b1, 6, 1'b0, 1'b1, 1'b0);

      // reserved opcodes behave as no-op; bubble with an md op does nothing
      cyc(1'b1, 20, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 31, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 4, 1'b0, 1'b1, 1'b0);

      // divu, reset in cycle 3, then busy forced while idle trips the sticky error
      cyc(1'b1, 3, 1'b0, 1'b1, 1'b0);
      wait_cycles(2, 1'b1);
      cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
      busy_mode = 1;
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
      busy_mode = 0;
      wait_cycles(2, 1'b0);
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);

      // unit drops busy early mid-divide
      cyc(1'b1, 4, 1'b0, 1'b0, 1'b0);
      wait_cycles(3, 1'b1);
      busy_mode = 2;
      cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
      busy_mode = 0;
      wait_cycles(8, 1'b1);
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         int   op;
         logic v, fl, du, rst;
         op  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 31)) : int'($urandom_range(0, 8));
         v   = ($urandom_range(0, 4) != 0);
         fl  = ($urandom_range(0, 7) == 0);
         du  = $urandom_range(0, 1) == 1;
         rst = ($urandom_range(0, 99) == 0);
         busy_mode = ($urandom_range(0, 199) == 0) ? int'($urandom_range(1, 2)) : 0;
         if (busy_mode != 0 && $urandom_range(0, 1) == 1) rst = 1'b1;
         cyc(v, op, fl, du, rst);
      end
      busy_mode = 0;
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
